// File: rtl/seq_digit_if.sv
// Display-side signal bundle for one HH:MM digit position: blink/edit
// controls and the digit value in, registered segment/select codes out.
interface seq_digit_if;
    logic       sec_en;
    logic [2:0] control_dig;
    logic [3:0] key;
    logic [3:0] dig;
    logic [7:0] smg;

    // master: time/edit logic feeding a digit; slave: the digit driver itself.
    // No handshake: inputs are sampled on every clk edge, outputs are
    // valid one cycle after the inputs they depend on.
    modport master (
        output sec_en,
        output control_dig,
        output key,
        input  dig,
        input  smg
    );

    modport slave (
        input  sec_en,
        input  control_dig,
        input  key,
        output dig,
        output smg
    );
endinterface

// File: rtl/seq_digit_control.sv
// Per-position 7-segment driver: decodes a digit, blanks it while it is being
// edited, and blinks the hour/minute separator dot. All outputs are registered.
module seq_digit_control #(
    parameter logic [1:0] DP_SEL    = 2'd1,
    parameter logic [2:0] EDIT_BASE = 3'd1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     sel,
    seq_digit_if.slave     bus
);

    logic [7:0] seg_code;
    logic       ctrl_in_range;
    logic       edit_hit;
    logic       blank;
    logic [3:0] dig_next;
    logic [7:0] smg_next;

    // Active-low {dp,g..a}; every entry carries dp = 1 (off).
    always_comb begin
        seg_code = 8'hFF;
        case (bus.key)
            4'h0: seg_code = 8'hC0;
            4'h1: seg_code = 8'hF9;
            4'h2: seg_code = 8'hA4;
            4'h3: seg_code = 8'hB0;
            4'h4: seg_code = 8'h99;
            4'h5: seg_code = 8'h92;
            4'h6: seg_code = 8'h82;
            4'h7: seg_code = 8'hF8;
            4'h8: seg_code = 8'h80;
            4'h9: seg_code = 8'h90;
            4'hA: seg_code = 8'h88;
            4'hB: seg_code = 8'h83;
            4'hC: seg_code = 8'hC6;
            4'hD: seg_code = 8'hA1;
            4'hE: seg_code = 8'h86;
            4'hF: seg_code = 8'h8E;
            default: seg_code = 8'hFF;
        endcase
    end

    // Selector values 5..7 mean run mode, so only 1..4 can ever hit a position.
    assign ctrl_in_range = (bus.control_dig != 3'd0) && (bus.control_dig <= 3'd4);
    assign edit_hit      = ctrl_in_range &&
                           (bus.control_dig == 3'(EDIT_BASE + {1'b0, sel}));
    assign blank         = edit_hit && !bus.sec_en;

    assign dig_next = ~(4'b1000 >> sel);

    always_comb begin
        smg_next = seg_code;
        if (blank) begin
            smg_next = 8'hFF;
        end else if (sel == DP_SEL) begin
            smg_next[7] = ~bus.sec_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dig <= 4'hF;
            bus.smg <= 8'hFF;
        end else begin
            bus.dig <= dig_next;
            bus.smg <= smg_next;
        end
    end

endmodule

// File: tb/tb_seq_digit_control.sv
// Directed bench for seq_digit_control: expected {dig,smg} words are queued
// as stimulus is applied and checked by a separate monitor one cycle later.
module tb_seq_digit_control;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel;

    seq_digit_if bus ();

    seq_digit_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];
    logic        drv_valid = 1'b0;
    logic        obs_pending = 1'b0;
    int          obs_idx = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got dig=%h smg=%h, want dig=%h smg=%h",
                     name, act[11:8], act[7:0], exp[11:8], exp[7:0]);
        end
    endtask

    // driver: set inputs at negedge, queue the response expected after the next posedge
    task automatic apply(input logic [1:0] s, input logic [2:0] ctrl, input logic [3:0] k,
                         input logic se, input logic [3:0] dig_e, input logic [7:0] smg_e);
        @(negedge clk);
        sel             = s;
        bus.control_dig = ctrl;
        bus.key         = k;
        bus.sec_en      = se;
        exp_q.push_back({dig_e, smg_e});
        drv_valid       = 1'b1;
        @(posedge clk);
        #1 drv_valid    = 1'b0;
    endtask

    // monitor
    always @(posedge clk) obs_pending <= drv_valid;

    always @(negedge clk) begin
        if (obs_pending) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL monitor: output %0d with no expectation queued", obs_idx);
            end else begin
                check($sformatf("vec%0d", obs_idx), {bus.dig, bus.smg}, exp_q.pop_front());
            end
            obs_idx++;
        end
    end

    logic [7:0] seg_tab[16];

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

        rst_n           = 1'b0;
        sel             = 2'd0;
        bus.control_dig = 3'd0;
        bus.key         = 4'd8;
        bus.sec_en      = 1'b1;

        // reset held across several edges
        repeat (3) @(posedge clk);
        #1 check("reset_hold", {bus.dig, bus.smg}, {4'hF, 8'hFF});

        @(negedge clk);
        rst_n = 1'b1;
        apply(2'd0, 3'd0, 4'd8, 1'b1, 4'b0111, 8'h80);

        // decode sweep on position 2
        for (int k = 0; k < 16; k++)
            apply(2'd2, 3'd0, 4'(k), 1'b0, 4'b1101, seg_tab[k]);

        // separator dot on position 1
        apply(2'd1, 3'd0, 4'd3, 1'b1, 4'b1011, 8'h30);
        apply(2'd1, 3'd0, 4'd3, 1'b0, 4'b1011, 8'hB0);

        // edit blink on position 3
        apply(2'd3, 3'd4, 4'd7, 1'b0, 4'b1110, 8'hFF);
        apply(2'd3, 3'd4, 4'd7, 1'b1, 4'b1110, 8'hF8);
        apply(2'd3, 3'd3, 4'd7, 1'b0, 4'b1110, 8'hF8);
        apply(2'd3, 3'd3, 4'd7, 1'b1, 4'b1110, 8'hF8);

        // edit on the dot position: blank wins, dot returns in the on half
        apply(2'd1, 3'd2, 4'd2, 1'b0, 4'b1011, 8'hFF);
        apply(2'd1, 3'd2, 4'd2, 1'b1, 4'b1011, 8'h24);
        apply(2'd1, 3'd3, 4'd0, 1'b1, 4'b1011, 8'h40);

        // position 0 edit, and out-of-range selectors act as run mode
        apply(2'd0, 3'd1, 4'd1, 1'b0, 4'b0111, 8'hFF);
        apply(2'd0, 3'd5, 4'd1, 1'b0, 4'b0111, 8'hF9);
        apply(2'd2, 3'd7, 4'd5, 1'b0, 4'b1101, 8'h92);
        apply(2'd3, 3'd6, 4'd9, 1'b0, 4'b1110, 8'h90);

        // drain, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        // async reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {bus.dig, bus.smg}, {4'hF, 8'hFF});
        @(negedge clk);
        rst_n = 1'b1;
        apply(2'd2, 3'd0, 4'd4, 1'b0, 4'b1101, 8'h99);
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: timeout, bench did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
